// File: rtl/dr_exponent_tx_pkg.sv
// Shared types for the asynchronous CORDIC exponent path: the dual-rail bit encoding
// and the state set of the synchronous-to-dual-rail transmitter.
package pa_AsyncCordic;

    localparam int EW = 7;

    typedef struct packed {
        logic data_1;
        logic data_0;
    } dual_rail_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RTZ  = 2'd2,
        DONE = 2'd3
    } tx_state_e;

    function automatic dual_rail_t encode_bit(input logic b);
        dual_rail_t r;
        r.data_1 = b;
        r.data_0 = ~b;
        return r;
    endfunction

endpackage

// File: rtl/dr_exponent_tx_sync2.sv
// Two-flop synchronizer bank for asynchronous handshake inputs.
module dr_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_p0;
    logic [W-1:0] sync_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            meta_p0 <= d;
            sync_p1 <= meta_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/dr_exponent_tx.sv
// Sends a binary exponent as a four-phase dual-rail token to an asynchronous
// zero-detector and returns its synchronized zero/non-zero verdict.
module dr_exponent_tx #(
    parameter int EW  = pa_AsyncCordic::EW,
    parameter int TMO = 255
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    input  logic [EW:0]                      in_exp,
    output logic                             in_ready,
    output pa_AsyncCordic::dual_rail_t [EW:0] exponent,
    input  logic                             ack_i,
    input  pa_AsyncCordic::dual_rail_t       ctrl,
    output logic                             ctrl_ack,
    output logic                             res_valid,
    output logic                             res_zero,
    input  logic                             res_ready,
    output logic                             err
);

    import pa_AsyncCordic::*;

    localparam int WD_W = $clog2(TMO + 1);

    typedef dual_rail_t [EW:0] rails_t;

    function automatic rails_t to_dual_rail(input logic [EW:0] w);
        rails_t r;
        for (int i = 0; i <= EW; i++) begin
            r[i] = encode_bit(w[i]);
        end
        return r;
    endfunction

    tx_state_e   state;
    tx_state_e   state_nxt;
    logic [EW:0] exp_p0;
    logic [WD_W-1:0] wdog;
    logic        ack_s;
    logic        c1_s;
    logic        c0_s;
    logic        accept;
    logic        data_exit;
    logic        illegal;
    logic        rtz_done;
    logic        tmo_hit;

    dr_sync2 #(
        .W(3)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   ({ack_i, ctrl.data_1, ctrl.data_0}),
        .q   ({ack_s, c1_s, c0_s})
    );

    assign in_ready = (state == IDLE) && !res_valid && !rst;
    assign tmo_hit  = (wdog == WD_W'(TMO - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        data_exit = 1'b0;
        illegal   = 1'b0;
        rtz_done  = 1'b0;
        case (state)
            IDLE: begin
                accept = in_valid && in_ready;
                if (accept) state_nxt = DATA;
            end
            DATA: begin
                // A both-rails-high verdict is a protocol violation but still ends the phase.
                illegal   = c1_s && c0_s;
                data_exit = illegal || (ack_s && (c1_s ^ c0_s));
                if (data_exit || tmo_hit) state_nxt = RTZ;
            end
            RTZ: begin
                rtz_done = !ack_s && !c1_s && !c0_s;
                if (rtz_done)     state_nxt = DONE;
                else if (tmo_hit) state_nxt = IDLE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Captured word is data only; the FSM decides whether it is ever used.
    always_ff @(posedge clk) begin
        if (accept) exp_p0 <= in_exp;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog <= '0;
        end else if ((state_nxt != state) || !((state == DATA) || (state == RTZ))) begin
            wdog <= '0;
        end else begin
            wdog <= wdog + WD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exponent  <= '0;
            ctrl_ack  <= 1'b0;
            res_valid <= 1'b0;
            res_zero  <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (res_valid && res_ready) res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    exponent <= '0;
                    ctrl_ack <= 1'b0;
                end
                DATA: begin
                    if (data_exit) begin
                        res_zero  <= c1_s && !c0_s;
                        res_valid <= 1'b1;
                        exponent  <= '0;
                        ctrl_ack  <= 1'b1;
                        if (illegal) err <= 1'b1;
                    end else if (tmo_hit) begin
                        err      <= 1'b1;
                        exponent <= '0;
                        ctrl_ack <= 1'b1;
                    end else begin
                        exponent <= to_dual_rail(exp_p0);
                    end
                end
                RTZ: begin
                    if (rtz_done) begin
                        ctrl_ack <= 1'b0;
                    end else if (tmo_hit) begin
                        err      <= 1'b1;
                        ctrl_ack <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dr_exponent_tx.sv
// Directed bench for dr_exponent_tx with a behavioural dual-rail zero-detector (3-cycle delay).
module tb_dr_exponent_tx;

    localparam int EW = pa_AsyncCordic::EW;

    logic                             clk;
    logic                             rst;
    logic                             in_valid;
    logic [EW:0]                      in_exp;
    logic                             in_ready;
    pa_AsyncCordic::dual_rail_t [EW:0] exponent;
    logic                             ack_i;
    pa_AsyncCordic::dual_rail_t       ctrl;
    logic                             ctrl_ack;
    logic                             res_valid;
    logic                             res_zero;
    logic                             res_ready;
    logic                             err;

    logic det_en;
    logic force_both;
    int   total;
    int   bad;

    dr_exponent_tx #(
        .EW  (EW),
        .TMO (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_exp    (in_exp),
        .in_ready  (in_ready),
        .exponent  (exponent),
        .ack_i     (ack_i),
        .ctrl      (ctrl),
        .ctrl_ack  (ctrl_ack),
        .res_valid (res_valid),
        .res_zero  (res_zero),
        .res_ready (res_ready),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Behavioural detector: a complete token produces ack plus a verdict three cycles later;
    // the spacer withdraws them three cycles later.
    logic       complete;
    logic       is_zero;
    logic       ack_d1, ack_d2, ack_d3;
    logic [1:0] c_d1, c_d2, c_d3;

    always_comb begin
        complete = 1'b1;
        is_zero  = 1'b1;
        for (int i = 0; i <= EW; i++) begin
            if (exponent[i].data_1 == exponent[i].data_0) complete = 1'b0;
            if (exponent[i].data_1) is_zero = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            ack_d1 <= 1'b0; ack_d2 <= 1'b0; ack_d3 <= 1'b0;
            c_d1 <= 2'b00; c_d2 <= 2'b00; c_d3 <= 2'b00;
        end else begin
            ack_d1 <= det_en && complete;
            c_d1   <= !(det_en && complete) ? 2'b00 :
                      force_both ? 2'b11 : (is_zero ? 2'b10 : 2'b01);
            ack_d2 <= ack_d1; c_d2 <= c_d1;
            ack_d3 <= ack_d2; c_d3 <= c_d2;
        end
    end

    assign ack_i       = ack_d3;
    assign ctrl.data_1 = c_d3[1];
    assign ctrl.data_0 = c_d3[0];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic send(input logic [EW:0] w, output bit ok);
        ok       = 1'b0;
        in_valid = 1'b1;
        in_exp   = w;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_res(output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (res_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_ack_low(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!ctrl_ack) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic take_result();
        @(negedge clk);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        total++; if (exponent !== 16'h0000) begin bad++; $display("FAIL rst_exponent: got %h want 0000", exponent); end
        total++; if ({ctrl_ack, res_valid, res_zero, err} !== 4'b0000) begin
            bad++; $display("FAIL rst_outputs: got ack/valid/zero/err=%b want 0000", {ctrl_ack, res_valid, res_zero, err});
        end
        rst = 1'b0;
        tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_zero();
        bit ok;
        int n;
        send(8'd0, ok);
        total++; if (!ok) begin bad++; $display("FAIL zero_accept: got no acceptance want accepted"); end
        wait_res(n, ok);
        total++; if (!ok) begin bad++; $display("FAIL zero_res_valid: got timeout want res_valid"); end
        total++; if (n != 7) begin bad++; $display("FAIL zero_latency: got %0d want 7", n); end
        total++; if (res_zero !== 1'b1) begin bad++; $display("FAIL zero_res_zero: got %b want 1", res_zero); end
        total++; if (exponent !== 16'h0000) begin bad++; $display("FAIL zero_spacer: got %h want 0000", exponent); end
        total++; if (ctrl_ack !== 1'b1) begin bad++; $display("FAIL zero_ctrl_ack_high: got %b want 1", ctrl_ack); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL zero_err: got %b want 0", err); end
        wait_ack_low(ok);
        total++; if (!ok) begin bad++; $display("FAIL zero_ctrl_ack_low: got stuck high want 0"); end
        take_result();
        total++; if ({res_valid, in_ready} !== 2'b01) begin
            bad++; $display("FAIL zero_handshake: got valid/ready=%b want 01", {res_valid, in_ready});
        end
    endtask

    task automatic test_five();
        bit ok;
        int n;
        send(8'd5, ok);
        total++; if (!ok) begin bad++; $display("FAIL five_accept: got no acceptance want accepted"); end
        tick();
        total++; if (exponent !== 16'h5566) begin bad++; $display("FAIL five_rails: got %h want 5566", exponent); end
        total++; if ({exponent[0].data_1, exponent[0].data_0} !== 2'b10) begin
            bad++; $display("FAIL five_bit0: got %b want 10", {exponent[0].data_1, exponent[0].data_0});
        end
        tick();
        total++; if (exponent !== 16'h5566) begin bad++; $display("FAIL five_rails_hold: got %h want 5566", exponent); end
        wait_res(n, ok);
        total++; if (!ok || res_zero !== 1'b0) begin
            bad++; $display("FAIL five_result: got ok=%b zero=%b want ok=1 zero=0", ok, res_zero);
        end
        wait_ack_low(ok);
        total++; if (!ok) begin bad++; $display("FAIL five_ctrl_ack_low: got stuck high want 0"); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int n;
        in_valid = 1'b1;
        in_exp   = 8'd3;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++; if (in_ready !== 1'b0 || exponent !== 16'h0000) begin
                bad++; $display("FAIL bp_hold[%0d]: got ready=%b rails=%h want 0/0000", i, in_ready, exponent);
            end
        end
        @(negedge clk);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        total++; if ({res_valid, in_ready} !== 2'b01 || exponent !== 16'h0000) begin
            bad++; $display("FAIL bp_release: got valid/ready=%b rails=%h want 01/0000", {res_valid, in_ready}, exponent);
        end
        tick();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_accept: got ready=%b want 0", in_ready); end
        in_valid = 1'b0;
        tick();
        total++; if (exponent !== 16'h555A) begin bad++; $display("FAIL bp_rails: got %h want 555a", exponent); end
        wait_res(n, ok);
        total++; if (!ok || res_zero !== 1'b0) begin
            bad++; $display("FAIL bp_result: got ok=%b zero=%b want ok=1 zero=0", ok, res_zero);
        end
        wait_ack_low(ok);
        take_result();
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        det_en = 1'b0;
        send(8'd9, ok);
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (err) begin
                ok = 1'b1;
                break;
            end
        end
        total++; if (!ok || n != 16) begin bad++; $display("FAIL tmo_err: got ok=%b cycles=%0d want ok=1 cycles=16", ok, n); end
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL tmo_res_valid: got %b want 0", res_valid); end
        repeat (3) tick();
        total++; if ({in_ready, ctrl_ack, err} !== 3'b101 || exponent !== 16'h0000) begin
            bad++; $display("FAIL tmo_idle: got ready/ack/err=%b rails=%h want 101/0000", {in_ready, ctrl_ack, err}, exponent);
        end
        det_en = 1'b1;
        do_reset();
        total++; if (err !== 1'b0) begin bad++; $display("FAIL tmo_err_clear: got %b want 0", err); end
    endtask

    task automatic test_illegal();
        bit ok;
        int n;
        force_both = 1'b1;
        send(8'd0, ok);
        wait_res(n, ok);
        total++; if (!ok) begin bad++; $display("FAIL illegal_res_valid: got timeout want res_valid"); end
        total++; if ({err, res_zero} !== 2'b10) begin
            bad++; $display("FAIL illegal_flags: got err/zero=%b want 10", {err, res_zero});
        end
        wait_ack_low(ok);
        take_result();
        force_both = 1'b0;
        do_reset();
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n;
        send(8'd6, ok);
        tick();
        total++; if (exponent !== 16'h5569) begin bad++; $display("FAIL mid_rails: got %h want 5569", exponent); end
        rst = 1'b1;
        tick();
        total++; if (exponent !== 16'h0000 || {in_ready, ctrl_ack, res_valid, res_zero, err} !== 5'b00000) begin
            bad++; $display("FAIL mid_abort: got rails=%h ready/ack/valid/zero/err=%b want 0000/00000",
                            exponent, {in_ready, ctrl_ack, res_valid, res_zero, err});
        end
        rst = 1'b0;
        repeat (8) tick();
        send(8'd0, ok);
        wait_res(n, ok);
        total++; if (!ok || {res_zero, err} !== 2'b10) begin
            bad++; $display("FAIL mid_clean: got ok=%b zero/err=%b want ok=1 10", ok, {res_zero, err});
        end
        wait_ack_low(ok);
        take_result();
    endtask

    initial begin
        clk        = 1'b0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_exp     = '0;
        res_ready  = 1'b0;
        det_en     = 1'b1;
        force_both = 1'b0;
        total      = 0;
        bad        = 0;
        test_reset();
        test_zero();
        test_five();
        test_backpressure();
        test_timeout();
        test_illegal();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dr_exponent_tx.md
DR_EXPONENT_TX -- requirements
Module: dr_exponent_tx

Interface
REQ-001 Parameter: EW, default pa_AsyncCordic::EW; the exponent width is EW+1 bits.
REQ-002 Parameter: TMO, default 255; watchdog limit in clock cycles for each handshake phase.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  a binary exponent word is offered.
REQ-006 in_exp  input  EW+1  binary exponent word.
REQ-007 in_ready  output  1  the word is accepted on a cycle where in_valid and in_ready are both high.
REQ-008 exponent  output  pa_AsyncCordic::dual_rail_t[EW:0]  dual-rail token toward the zero-detector.
REQ-009 ack_i  input  1  asynchronous acknowledge from the zero-detector's completion sink.
REQ-010 ctrl  input  pa_AsyncCordic::dual_rail_t  asynchronous dual-rail zero/non-zero result.
REQ-011 ctrl_ack  output  1  acknowledge for ctrl; high forces the detector's result back to spacer.
REQ-012 res_valid  output  1  result held for the consumer.
REQ-013 res_zero  output  1  1 means the sent exponent equalled zero.
REQ-014 res_ready  input  1  the consumer takes the result when res_valid and res_ready are both high.
REQ-015 err  output  1  sticky error flag: either a watchdog timeout or an illegal dual-rail code.

Function
REQ-016 ack_i, ctrl.data_1 and ctrl.data_0 SHALL each pass through a 2-flop synchronizer before use; below, ack_s, c1_s and c0_s denote the synchronized values.
REQ-017 The FSM SHALL have four states: IDLE, DATA, RTZ and DONE.
REQ-018 IDLE: in_ready = !res_valid; exponent all-spacer (both rails 0); ctrl_ack = 0.
REQ-019 IDLE -> DATA on acceptance: register in_exp; on the next edge drive data_1 = bit and data_0 = ~bit for every bit.
REQ-020 DATA: hold the rails stable until ack_s = 1 and exactly one of c1_s/c0_s = 1.
REQ-021 DATA exit: capture res_zero = c1_s, set res_valid, drive exponent to spacer, set ctrl_ack = 1, go to RTZ.
REQ-022 DATA: c1_s = c0_s = 1 SHALL set err and be treated as exit with res_zero = 0.
REQ-023 RTZ: wait until ack_s = 0 and c1_s = c0_s = 0, then clear ctrl_ack and go to DONE.
REQ-024 DONE: go to IDLE on the next cycle; this guarantees at least one spacer cycle with ctrl_ack low.
REQ-025 res_valid SHALL clear on the handshake; a new word is not accepted while res_valid = 1, so there is no overwrite.
REQ-026 A simultaneous res_valid/res_ready handshake and in_valid in IDLE: the word is accepted on the following cycle, not the same one.
REQ-027 Watchdog: a counter is cleared on every state entry and increments in DATA and in RTZ.
REQ-028 Watchdog reaching TMO in DATA: set err, force spacer with ctrl_ack = 1, go to RTZ, and do not set res_valid.
REQ-029 Watchdog reaching TMO in RTZ: set err, clear ctrl_ack, go to IDLE.
REQ-030 Minimum latency from acceptance to res_valid: 1 (drive) + 2 (synchronizer) + 1 (capture) = 4 cycles, plus the detector delay.
REQ-031 err SHALL clear only on rst.

Reset
REQ-032 rst SHALL set: state = IDLE, exponent all 0, ctrl_ack = 0, res_valid = 0, res_zero = 0, err = 0, watchdog = 0, all synchronizer flops = 0.
REQ-033 rst asserted mid-transaction SHALL abort the transaction: rails go to spacer on the next edge and the captured word is discarded.
REQ-034 With rst held, in_ready SHALL be 0.

Structure
REQ-035 dual_rail_t and EW SHALL live in pa_AsyncCordic; the FSM state enum (IDLE, DATA, RTZ, DONE) SHALL be added to pa_AsyncCordic as tx_state_e.
REQ-036 One sub-module, dr_sync2 (parameterized 2-flop synchronizer, width param, synchronous reset), SHALL be instantiated once with width 3.
REQ-037 The watchdog width SHALL be $clog2(TMO+1).

Verification
REQ-038 in_exp = 0 sent to a behavioural detector with ack/ctrl delay of 3 cycles -> res_valid = 1 with res_zero = 1, exponent returns to spacer, ctrl_ack pulses, err = 0.
REQ-039 in_exp = 5 -> res_zero = 0; exactly one rail is high per bit during DATA; bit 0 has data_1 = 1.
REQ-040 res_ready held 0 for 10 cycles with in_valid = 1 -> in_ready stays 0 and no second token is driven; after res_ready = 1 the next word is sent.
REQ-041 ack_i never asserted, TMO = 16 -> err = 1 after 16 cycles in DATA, res_valid stays 0, FSM returns to IDLE.
REQ-042 ctrl both rails forced high -> err = 1 and res_zero = 0.
REQ-043 rst pulsed 2 cycles after acceptance -> all outputs at their reset values on the next edge, then a clean transaction completes.
